// File: rtl/serial_path_arb.sv
`default_nettype none
// ============================================================================
// Module      : serial_path_arb
// Description : Two-requester round-robin arbiter in front of a shared
//               single-bit serial path. The granted byte is shifted out MSB
//               first on path_out while the returning bits on path_in are
//               reassembled into result. A completed transfer raises done for
//               one cycle and flags inv_err when the returned byte is not the
//               bitwise inverse of the byte that was sent.
//
// Ports       : clk        in   clock, all state updates on rising edge
//               rst        in   synchronous active-high reset
//               req_a      in   requester A transfer request
//               data_a     in   [7:0] requester A byte
//               req_b      in   requester B transfer request
//               data_b     in   [7:0] requester B byte
//               path_in    in   return bit from the shared path
//               gnt_a      out  one-cycle grant pulse to A
//               gnt_b      out  one-cycle grant pulse to B
//               path_out   out  bit driven into the shared path
//               busy       out  transfer in progress (SHIFT or DONE)
//               done       out  one-cycle completion pulse
//               result     out  [7:0] byte reassembled from path_in
//               result_id  out  owner of result (0=A, 1=B)
//               inv_err    out  result is not ~sent byte, valid with done
//
// Revision    : 1.0 - initial release
// ============================================================================
module serial_path_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic [7:0] data_a,
    input  logic       req_b,
    input  logic [7:0] data_b,
    input  logic       path_in,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       path_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       result_id,
    output logic       inv_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] c_LAST_SHIFT = 3'd7;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_sh;
    logic [7:0] r_acc;
    logic [2:0] r_cnt;
    logic [7:0] r_sent;
    logic [7:0] r_result;
    logic       r_result_id;
    logic       r_last_id;
    logic       r_cur_id;
    logic       r_gnt_a;
    logic       r_gnt_b;

    logic       w_accept;
    logic       w_sel_id;
    logic [7:0] w_sel_data;
    logic       w_last_shift;

    // Requests only matter in IDLE. With both requesting, the one that was
    // not granted last time wins; otherwise whichever is requesting wins.
    assign w_accept     = (r_state == S_IDLE) && (req_a || req_b);
    assign w_sel_id     = (req_a && req_b) ? ~r_last_id : req_b;
    assign w_sel_data   = w_sel_id ? data_b : data_a;
    assign w_last_shift = (r_state == S_SHIFT) && (r_cnt == c_LAST_SHIFT);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)     w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last_shift) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sh        <= 8'h00;
            r_acc       <= 8'h00;
            r_cnt       <= 3'd0;
            r_sent      <= 8'h00;
            r_result    <= 8'h00;
            r_result_id <= 1'b0;
            r_last_id   <= 1'b1;    // A wins the first contention
            r_cur_id    <= 1'b0;
            r_gnt_a     <= 1'b0;
            r_gnt_b     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt_a <= w_accept && !w_sel_id;
            r_gnt_b <= w_accept &&  w_sel_id;

            if (w_accept) begin
                r_sh      <= w_sel_data;
                r_sent    <= w_sel_data;
                r_acc     <= 8'h00;
                r_cnt     <= 3'd0;
                r_last_id <= w_sel_id;
                r_cur_id  <= w_sel_id;
            end else if (r_state == S_SHIFT) begin
                r_sh  <= {r_sh[6:0], 1'b0};
                r_acc <= {r_acc[6:0], path_in};
                r_cnt <= r_cnt + 3'd1;
                // The final returned bit is folded in directly so result is
                // complete in the same edge that enters DONE.
                if (w_last_shift) begin
                    r_result    <= {r_acc[6:0], path_in};
                    r_result_id <= r_cur_id;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign gnt_a     = r_gnt_a;
    assign gnt_b     = r_gnt_b;
    assign path_out  = (r_state == S_SHIFT) && r_sh[7];
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign result    = r_result;
    assign result_id = r_result_id;
    assign inv_err   = (r_state == S_DONE) && (r_result != ~r_sent);

endmodule

`default_nettype wire

// File: tb/tb_serial_path_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_path_arb
// Description : Directed self-checking bench for serial_path_arb. The shared
//               path is modelled as an inverter (or stuck at 0 when fault is
//               set). Inputs change and outputs are sampled 1 time unit after
//               each rising clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_path_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a;
    logic [7:0] data_a;
    logic       req_b;
    logic [7:0] data_b;
    logic       path_in;
    logic       gnt_a;
    logic       gnt_b;
    logic       path_out;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       result_id;
    logic       inv_err;

    logic       fault = 1'b0;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cycle    = 0;

    always #5 clk = ~clk;

    assign path_in = fault ? 1'b0 : ~path_out;

    serial_path_arb dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .data_a    (data_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .path_in   (path_in),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .path_out  (path_out),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_id (result_id),
        .inv_err   (inv_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Steps until a grant pulse is visible; a timeout counts as a failure.
    task automatic wait_gnt(input string tag);
        int n;
        n = 0;
        while (!(gnt_a || gnt_b) && n < 30) begin
            step();
            n++;
        end
        chk({tag, "_gnt_seen"}, {31'd0, (gnt_a || gnt_b)}, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 30) begin
            step();
            n++;
        end
        chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_bits;
        int         t_done [3];
        logic [2:0] exp_gnt_a;
        logic [7:0] exp_res [3];
        logic [2:0] exp_id;

        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; data_a = 8'h00; data_b = 8'h00;
        do_reset();

        // ---------------- reset state ----------------
        chk("rst_busy",     {31'd0, busy},      32'd0);
        chk("rst_done",     {31'd0, done},      32'd0);
        chk("rst_gnt",      {30'd0, gnt_a, gnt_b}, 32'd0);
        chk("rst_path_out", {31'd0, path_out},  32'd0);
        chk("rst_result",   {24'd0, result},    32'h00);
        chk("rst_res_id",   {31'd0, result_id}, 32'd0);
        chk("rst_inv_err",  {31'd0, inv_err},   32'd0);

        // ---------------- single A transfer ----------------
        data_a = 8'hA5; req_a = 1'b1;
        step();                             // E0
        req_a = 1'b0;
        chk("a_gnt_a", {31'd0, gnt_a}, 32'd1);
        chk("a_gnt_b", {31'd0, gnt_b}, 32'd0);
        chk("a_busy",  {31'd0, busy},  32'd1);
        exp_bits = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("a_path_bit%0d", i), {31'd0, path_out}, {31'd0, exp_bits[7-i]});
            chk($sformatf("a_done_early%0d", i), {31'd0, done}, 32'd0);
            step();                         // E1..E8
            if (i == 0) chk("a_gnt_pulse", {31'd0, gnt_a}, 32'd0);
        end
        chk("a_done",     {31'd0, done},      32'd1);
        chk("a_path_dn",  {31'd0, path_out},  32'd0);
        chk("a_result",   {24'd0, result},    32'h5A);
        chk("a_res_id",   {31'd0, result_id}, 32'd0);
        chk("a_inv_err",  {31'd0, inv_err},   32'd0);
        step();                             // E9
        chk("a_done_pulse", {31'd0, done}, 32'd0);
        chk("a_idle_busy",  {31'd0, busy}, 32'd0);
        chk("a_hold",       {24'd0, result}, 32'h5A);

        // ---------------- contention ----------------
        do_reset();
        data_a = 8'h0F; data_b = 8'hF0; req_a = 1'b1; req_b = 1'b1;
        exp_gnt_a = 3'b101;
        exp_res[0] = 8'hF0; exp_res[1] = 8'h0F; exp_res[2] = 8'hF0;
        exp_id = 3'b010;
        for (int k = 0; k < 3; k++) begin
            wait_gnt($sformatf("c%0d", k));
            chk($sformatf("c%0d_gnt_a", k), {31'd0, gnt_a}, {31'd0, exp_gnt_a[k]});
            chk($sformatf("c%0d_gnt_b", k), {31'd0, gnt_b}, {31'd0, ~exp_gnt_a[k]});
            wait_done($sformatf("c%0d", k));
            t_done[k] = cycle;
            chk($sformatf("c%0d_result", k), {24'd0, result},    {24'd0, exp_res[k]});
            chk($sformatf("c%0d_res_id", k), {31'd0, result_id}, {31'd0, exp_id[k]});
            if (k > 0) chk($sformatf("c%0d_spacing", k), t_done[k] - t_done[k-1], 32'd10);
        end
        req_a = 1'b0; req_b = 1'b0;
        step();                             // DONE -> IDLE

        // ---------------- reset mid-operation ----------------
        data_a = 8'hA5; req_a = 1'b1;
        step();                             // E0
        req_a = 1'b0;
        chk("r_gnt_a", {31'd0, gnt_a}, 32'd1);
        step(); step(); step();             // E1..E3
        rst = 1'b1;
        step();                             // E4 with reset
        rst = 1'b0;
        chk("r_busy",   {31'd0, busy},      32'd0);
        chk("r_done",   {31'd0, done},      32'd0);
        chk("r_result", {24'd0, result},    32'h00);
        chk("r_res_id", {31'd0, result_id}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("r_no_done%0d", i), {31'd0, done}, 32'd0);
        end
        data_a = 8'h33; data_b = 8'h44; req_a = 1'b1; req_b = 1'b1;
        wait_gnt("r_cont");
        chk("r_cont_a_first", {30'd0, gnt_a, gnt_b}, 32'b10);
        req_a = 1'b0; req_b = 1'b0;
        wait_done("r_cont");
        chk("r_cont_result", {24'd0, result}, 32'hCC);
        step();

        // ---------------- request drop ----------------
        data_b = 8'hC3; req_b = 1'b1;
        wait_gnt("d_b");
        chk("d_gnt_b", {30'd0, gnt_a, gnt_b}, 32'b01);
        req_b = 1'b0;
        step(); step();                     // in SHIFT
        data_a = 8'h5A; req_a = 1'b1;
        wait_done("d_b");
        chk("d_b_result", {24'd0, result},    32'h3C);
        chk("d_b_res_id", {31'd0, result_id}, 32'd1);
        step();                             // E9: DONE -> IDLE, no accept
        chk("d_e9_gnt",  {30'd0, gnt_a, gnt_b}, 32'd0);
        chk("d_e9_busy", {31'd0, busy}, 32'd0);
        step();                             // E10: accept A
        chk("d_e10_gnt", {30'd0, gnt_a, gnt_b}, 32'b10);
        req_a = 1'b0;
        wait_done("d_a");
        chk("d_a_result", {24'd0, result},    32'hA5);
        chk("d_a_res_id", {31'd0, result_id}, 32'd0);
        step();

        // ---------------- faulty path ----------------
        fault = 1'b1;
        data_b = 8'h3C; req_b = 1'b1;
        wait_gnt("f");
        chk("f_gnt_b", {30'd0, gnt_a, gnt_b}, 32'b01);
        req_b = 1'b0;
        chk("f_inv_err_shift", {31'd0, inv_err}, 32'd0);
        wait_done("f");
        chk("f_result",  {24'd0, result},    32'h00);
        chk("f_res_id",  {31'd0, result_id}, 32'd1);
        chk("f_inv_err", {31'd0, inv_err},   32'd1);
        step();
        chk("f_inv_err_after", {31'd0, inv_err}, 32'd0);
        chk("f_done_after",    {31'd0, done},    32'd0);
        chk("f_hold_id",       {31'd0, result_id}, 32'd1);
        fault = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
